// File: rtl/spram_rd_streamer.sv
// Read-side sequencer for a single-port SRAM: turns a (base, length) command into sequential
// reads, absorbs the fixed read latency and presents the words on a valid/ready stream.
module spram_rd_streamer #(
    parameter int DW         = 64,
    parameter int AW         = 8,
    parameter int DEPTH      = 256,
    parameter int N_DELAY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = $clog2(N_DELAY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     issued_q, issued_d;
    logic [AW:0]     popped_q, popped_d;
    logic [N_DELAY-1:0] tracker_q, tracker_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   fifo_mem [FIFO_DEPTH];

    logic [IW-1:0]   inflight;
    logic            issue;
    logic            push;
    logic            pop;

    assign mem_we   = 1'b0;
    assign mem_addr = addr_q;
    assign m_valid  = (count_q != '0);
    assign m_data   = m_valid ? fifo_mem[rd_ptr_q] : '0;
    // The FIFO head is always word number popped_q of the command.
    assign m_last   = m_valid && (popped_q == (len_q - 1'b1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            inflight = inflight + IW'(tracker_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        popped_d  = popped_q;
        tracker_d = tracker_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        mem_cs    = (state_q == S_RUN) || (state_q == S_FLUSH);

        // Credit: everything already in flight must still fit when it lands.
        issue = (state_q == S_RUN) && ((int'(count_q) + int'(inflight)) < FIFO_DEPTH);
        push  = mem_cs && tracker_q[N_DELAY-1];
        pop   = m_valid && m_ready;

        // The SRAM delay chain only advances while selected, so the tracker follows it.
        if (mem_cs) begin
            tracker_d    = tracker_q << 1;
            tracker_d[0] = issue;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            popped_d = popped_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_base;
                    len_d    = cmd_len;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d   = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if ((issued_q + 1'b1) == len_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if ((inflight == '0) && (count_d == '0) && (popped_d == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            tracker_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            popped_q  <= popped_d;
            tracker_q <= tracker_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count_q covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule
